// File: rtl/inst_stream_loader.sv
// Framed program loader: word-count header, big-endian payload words
// written to instruction BRAM port A, then a payload checksum byte.
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   en, data    received byte strobe and byte
//   clear       synchronous restart to header parsing (BRAM untouched)
//   inst_addra  BRAM byte address of the current write
//   inst_dina   assembled big-endian word
//   inst_wea    4'b1111 for one cycle per written word
//   word_count  words written so far in this frame
//   done        frame loaded and checksum matched (sticky)
//   error       bad checksum or oversize count (sticky)
module inst_stream_loader #(
   parameter int MAX_WORDS = 16384,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [7:0]       data,
   input  logic             clear,
   output logic [31:0]      inst_addra,
   output logic [31:0]      inst_dina,
   output logic [3:0]       inst_wea,
   output logic [CNT_W-1:0] word_count,
   output logic             done,
   output logic             error
);

   typedef enum logic [2:0] {
      HDR,
      PAY,
      CHK,
      DONE,
      ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  byte_idx;
   logic [31:0] hdr;
   logic [23:0] word_sh;
   logic [7:0]  sum;

   logic [31:0] hdr_nxt;
   logic [31:0] word_nxt;
   logic [31:0] wc32;
   logic        last_word;

   assign hdr_nxt   = {hdr[23:0], data};
   assign word_nxt  = {word_sh, data};
   assign wc32      = 32'(word_count);
   // the word being completed is the final one of the frame
   assign last_word = (wc32 + 32'd1 == hdr);

   // state register
   always_ff @(posedge clk) begin
      if (!rstn) state <= HDR;
      else       state <= state_nxt;
   end

   // next-state logic; clear wins over a same-cycle byte
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = HDR;
      end else if (en) begin
         unique case (state)
            HDR: begin
               if (byte_idx == 2'd3) begin
                  if (hdr_nxt == 32'd0)
                     state_nxt = CHK;
                  else if (hdr_nxt > 32'(MAX_WORDS))
                     state_nxt = ERR;
                  else
                     state_nxt = PAY;
               end
            end
            PAY: begin
               if (byte_idx == 2'd3 && last_word)
                  state_nxt = CHK;
            end
            CHK: state_nxt = (data == sum) ? DONE : ERR;
            default: state_nxt = state;
         endcase
      end
   end

   // status outputs follow the terminal states, so they are exclusive
   always_comb begin
      done  = (state == DONE);
      error = (state == ERR);
   end

   // datapath: byte assembly, checksum and registered write port
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         byte_idx   <= 2'd0;
         hdr        <= 32'd0;
         word_sh    <= 24'd0;
         sum        <= 8'd0;
         word_count <= '0;
         inst_addra <= 32'd0;
         inst_dina  <= 32'd0;
         inst_wea   <= 4'b0000;
      end else begin
         inst_wea <= 4'b0000;
         if (en) begin
            unique case (state)
               HDR: begin
                  hdr      <= hdr_nxt;
                  byte_idx <= byte_idx + 2'd1;
               end
               PAY: begin
                  word_sh  <= word_nxt[23:0];
                  sum      <= sum + data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     inst_dina  <= word_nxt;
                     inst_addra <= {wc32[29:0], 2'b00};
                     inst_wea   <= 4'b1111;
                     word_count <= word_count + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/inst_stream_loader.md
Name: inst_stream_loader

Overview:
Framed program loader that sits directly downstream of the UART receive path during the CPU's load phase. It consumes the received byte stream (one-cycle strobe plus byte) and assembles big-endian 32-bit instruction words. Each word is written to instruction BRAM port A. Framing is a word-count header, then the payload, then a checksum byte; done/error flags let the control FSM gate the transition to run mode.

Parameters:
MAX_WORDS, 16384, largest accepted word count; a larger header value is an error.
CNT_W, 32, width of the header count and of word_count.

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
en  input  1  byte strobe, one cycle per received byte; back-to-back strobes are legal
data  input  8  received byte, valid when en=1
clear  input  1  synchronous restart to HDR; outputs return to reset values; loaded BRAM contents are untouched
inst_addra  output  32  BRAM byte address = word_index<<2; bits [1:0] always 0
inst_dina  output  32  assembled word
inst_wea  output  4  4'b1111 for exactly one cycle per word, else 4'b0000
word_count  output  CNT_W  words written so far
done  output  1  frame loaded and checksum matched; sticky until clear/reset
error  output  1  checksum mismatch or count > MAX_WORDS; sticky until clear/reset

Behaviour:
- Reset (rstn=0 at posedge): state=HDR; byte_idx=0, sum=0, word_count=0; inst_addra=0, inst_dina=0, inst_wea=0, done=0, error=0.
- Reset or clear mid-frame: abort immediately, with no further writes. Words already written stay in BRAM.
- Clear takes priority over en in the same cycle; that byte is dropped.
- States: HDR, PAY, CHK, DONE, ERR.
- Bytes are consumed only on cycles with en=1. A 2-bit byte_idx counts 0..3 and wraps within each word.
- HDR:
  - Shift in 4 bytes MSB first into N.
  - On the 4th byte: if N==0, go to CHK. If N>MAX_WORDS, go to ERR with error=1. Otherwise go to PAY.
- PAY:
  - Each byte is shifted into a word register MSB first, and sum = (sum + data) mod 256.
  - On the 4th byte, the next cycle drives: inst_dina = assembled word, inst_addra = word_count<<2, inst_wea = 4'b1111.
  - In that same next cycle word_count increments. The write pulse is registered and never lasts more than one cycle.
  - A byte arriving during the write-pulse cycle is accepted normally; full 1-byte-per-cycle throughput is sustained.
  - When the write for word N is issued, the state moves to CHK in that same cycle.
- CHK:
  - The next byte is compared with sum (payload bytes only; the header is excluded).
  - Equal: DONE with done=1. Unequal: ERR with error=1.
- DONE/ERR: all en strobes are ignored, with no writes and no counter changes, until clear or reset.
- done and error are never both 1.
- inst_addra holds its last value between writes. The address wraps naturally at 2^30 words; this cannot be reached because of MAX_WORDS.

Test Plan:
- Frame 00 00 00 02 | 12 34 56 78 | 9A BC DE F0 | 38, sent back-to-back:
  - Two write pulses: addr 0x0 / data 0x12345678, then addr 0x4 / data 0x9ABCDEF0.
  - word_count=2, then done=1, error=0.
- Same frame with checksum 0x39:
  - Both writes still occur, then error=1, done=0.
  - 5 further strobes cause no wea activity.
- Header 00 00 00 00, then 00:
  - No write pulses; done=1 after the checksum byte.
  - Checksum 01 instead gives error=1.
- Header 00 00 40 01 with MAX_WORDS=16384:
  - error=1 on the 4th header byte; following bytes produce no writes.
- One idle cycle between every byte of the first frame:
  - Results identical to the first scenario; wea high exactly 2 cycles total.
- Reset during the 2nd payload word (after bytes 9A BC), then the first frame resent:
  - Outputs go to zero on reset.
  - Reload writes addr 0x0 and 0x4 correctly and ends done=1.
  - Repeat using clear instead of rstn, asserted in the same cycle as an en strobe: that byte is dropped and the result is the same.
